pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        MULTI = 1'b1
    } state_e;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctl_t;

    localparam int unsigned MULTI_LAT_MIN = 2;
    localparam int unsigned MULTI_LAT_MAX = 16;

    function automatic bit multi_lat_legal(input int unsigned lat);
        return (lat >= MULTI_LAT_MIN) && (lat <= MULTI_LAT_MAX);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side hazard inputs and per-stage control outputs of pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_W = 5
);
    logic [REG_W-1:0] id_rs_i;
    logic [REG_W-1:0] id_rt_i;
    logic             id_uses_rt_i;
    logic             ex_memread_i;
    logic [REG_W-1:0] ex_rt_i;
    logic             ex_branch_taken_i;
    logic             ex_multi_i;
    logic             mem_wait_i;

    logic pc_write_o;
    logic ifid_stall_o;
    logic ifid_flush_o;
    logic idex_stall_o;
    logic idex_flush_o;
    logic exmem_stall_o;
    logic exmem_flush_o;
    logic memwb_stall_o;
    logic memwb_flush_o;
    logic busy_o;

    // master: the pipeline, which reports hazards and obeys the controls
    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i,
               ex_branch_taken_i, ex_multi_i, mem_wait_i,
        input  pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o,
               exmem_stall_o, exmem_flush_o, memwb_stall_o, memwb_flush_o, busy_o
    );

    // slave: the hazard controller
    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i,
               ex_branch_taken_i, ex_multi_i, mem_wait_i,
        output pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o,
               exmem_stall_o, exmem_flush_o, memwb_stall_o, memwb_flush_o, busy_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard comparator: a load in EX writes a register the ID instruction reads.
module hazard_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             luh
);

    // register 0 is hardwired zero, so a load targeting it never creates a dependency
    always_comb begin
        luh = ex_memread && (ex_rt != '0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: per-stage stall/flush and PC write enable.
// Optional performance counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULTI_LAT = 4,
    parameter int unsigned REG_W     = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_hazard_ctrl_if.slave bus
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(MULTI_LAT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULTI_LAT - 2);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_multi;
    logic             cnt_nz;
    logic             luh;
    logic             ms;
    logic             br;
    logic             pc_write;
    stage_ctl_t       ifid, idex, exmem, memwb;

    hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard_detect (
        .ex_memread (bus.ex_memread_i),
        .ex_rt      (bus.ex_rt_i),
        .id_rs      (bus.id_rs_i),
        .id_rt      (bus.id_rt_i),
        .id_uses_rt (bus.id_uses_rt_i),
        .luh        (luh)
    );

    always_comb begin
        in_multi = (state_q == MULTI);
        cnt_nz   = (cnt_q != '0);
        ms       = (!in_multi && bus.ex_multi_i) || (in_multi && cnt_nz);
        // the branch in EX is frozen behind a multi-cycle op, so it only counts in RUN
        br       = bus.ex_branch_taken_i && !in_multi;
    end

    always_comb begin
        pc_write = 1'b0;
        ifid     = '0;
        idex     = '0;
        exmem    = '0;
        memwb    = '0;
        if (rst_i) begin
            if (bus.mem_wait_i) begin
                ifid.stall  = 1'b1;
                idex.stall  = 1'b1;
                exmem.stall = 1'b1;
                memwb.flush = 1'b1;
            end else if (br) begin
                pc_write   = 1'b1;
                ifid.flush = 1'b1;
                idex.flush = 1'b1;
            end else if (ms) begin
                ifid.stall  = 1'b1;
                idex.stall  = 1'b1;
                exmem.flush = 1'b1;
            end else if (luh) begin
                ifid.stall = 1'b1;
                idex.flush = 1'b1;
            end else begin
                pc_write = 1'b1;
            end
        end
    end

    always_comb begin
        bus.pc_write_o    = pc_write;
        bus.ifid_stall_o  = ifid.stall;
        bus.ifid_flush_o  = ifid.flush;
        bus.idex_stall_o  = idex.stall;
        bus.idex_flush_o  = idex.flush;
        bus.exmem_stall_o = exmem.stall;
        bus.exmem_flush_o = exmem.flush;
        bus.memwb_stall_o = memwb.stall;
        bus.memwb_flush_o = memwb.flush;
        bus.busy_o        = rst_i && in_multi;
    end

    // The RUN cycle that sees ex_multi_i is the first EX cycle, so MULTI counts
    // MULTI_LAT-2 more stall cycles and then spends one release cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (!bus.mem_wait_i) begin
            case (state_q)
                RUN: begin
                    if (bus.ex_multi_i && !bus.ex_branch_taken_i) begin
                        state_q <= MULTI;
                        cnt_q   <= CNT_INIT;
                    end
                end
                MULTI: begin
                    if (cnt_nz) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (!pc_write) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (ifid.flush) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MULTI_LAT=4).
module tb_pipe_hazard_ctrl;

    localparam int unsigned REG_W = 5;

    // {pc_write, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_s, memwb_f, busy}
    localparam logic [9:0] E_ZERO = 10'b0_0_0_0_0_0_0_0_0_0;
    localparam logic [9:0] E_RUN  = 10'b1_0_0_0_0_0_0_0_0_0;
    localparam logic [9:0] E_LUH  = 10'b0_1_0_0_1_0_0_0_0_0;
    localparam logic [9:0] E_BR   = 10'b1_0_1_0_1_0_0_0_0_0;
    localparam logic [9:0] E_MS   = 10'b0_1_0_1_0_0_1_0_0_0;
    localparam logic [9:0] E_WAIT = 10'b0_1_0_1_0_1_0_0_1_0;
    localparam logic [9:0] B      = 10'b0_0_0_0_0_0_0_0_0_1;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   stall_m;
    int   flush_m;
    logic [9:0] sb_q[$];
    logic [9:0] obs;

    pipe_hazard_ctrl_if #(.REG_W(REG_W)) bus ();

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipe_hazard_ctrl #(
        .MULTI_LAT(4),
        .REG_W    (REG_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    assign obs = {bus.pc_write_o, bus.ifid_stall_o, bus.ifid_flush_o, bus.idex_stall_o,
                  bus.idex_flush_o, bus.exmem_stall_o, bus.exmem_flush_o,
                  bus.memwb_stall_o, bus.memwb_flush_o, bus.busy_o};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic memrd, input logic [4:0] exrt, input logic brt,
                         input logic multi, input logic wt);
        bus.id_rs_i           = rs;
        bus.id_rt_i           = rt;
        bus.id_uses_rt_i      = uses;
        bus.ex_memread_i      = memrd;
        bus.ex_rt_i           = exrt;
        bus.ex_branch_taken_i = brt;
        bus.ex_multi_i        = multi;
        bus.mem_wait_i        = wt;
    endtask

    task automatic check_now(input string tag);
        logic [9:0] exp;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty obs=%b", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            total++;
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
            end
        end
    endtask

    // one clock cycle with inputs already driven: check mid-cycle, then advance
    task automatic cyc(input logic [9:0] exp, input string tag);
        sb_q.push_back(exp);
        @(negedge clk);
        check_now(tag);
        @(posedge clk);
        if (rst_n) begin
            if (!exp[9]) stall_m++;
            if (exp[7])  flush_m++;
        end
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        stall_m = 0;
        flush_m = 0;
        rst_n   = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #2;
        sb_q.push_back(E_ZERO);
        check_now("reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // load-use on rs, rs with r0 destination, rt path, rt ignored
        drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        cyc(E_LUH, "luh_rs");
        drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(E_RUN, "luh_r0");
        drive(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        cyc(E_LUH, "luh_rt");
        drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        cyc(E_RUN, "luh_rt_unused");
        drive(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
        cyc(E_RUN, "no_load");

        // taken branch masks luh and ex_multi (no MULTI entry)
        drive(5'd1, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        cyc(E_BR, "br_luh");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        cyc(E_BR, "br_multi");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(E_RUN, "br_multi_after");

        // full multi-cycle sequence; branch ignored in MULTI; no retrigger on release
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc(E_MS, "ms_c0");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        cyc(E_MS | B, "ms_c1_br_ignored");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc(E_MS | B, "ms_c2");
        cyc(E_RUN | B, "ms_release");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(E_RUN, "ms_back_run");

        // mem_wait in RUN with ex_multi: state holds RUN
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        cyc(E_WAIT, "wait_run");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(E_RUN, "wait_run_after");

        // mem_wait for 2 cycles at cnt=1; still 3 multi stalls in total
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc(E_MS, "mw_c0");
        cyc(E_MS | B, "mw_c1");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        cyc(E_WAIT | B, "mw_wait0");
        cyc(E_WAIT | B, "mw_wait1");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc(E_MS | B, "mw_c2");
        cyc(E_RUN | B, "mw_release");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(E_RUN, "mw_back_run");

        // reset mid-MULTI, then a full restart
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc(E_MS, "rs_c0");
        cyc(E_MS | B, "rs_c1");
        rst_n = 1'b0;
        #1;
        sb_q.push_back(E_ZERO);
        check_now("rs_mid_multi");
        stall_m = 0;
        flush_m = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(E_RUN, "rs_after_run");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc(E_MS, "rs_restart_c0");
        cyc(E_MS | B, "rs_restart_c1");
        cyc(E_MS | B, "rs_restart_c2");
        cyc(E_RUN | B, "rs_restart_release");
        drive(8'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc(E_BR, "rs_final_br");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
        total++;
        assert (stall_cnt === 32'(stall_m)) else begin
            bad++;
            $error("FAIL perf_stall: observed=%0d expected=%0d", stall_cnt, stall_m);
        end
        total++;
        assert (flush_cnt === 32'(flush_m)) else begin
            bad++;
            $error("FAIL perf_flush: observed=%0d expected=%0d", flush_cnt, flush_m);
        end
`endif

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: observed=%0d expected=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
